audio_sample_feeder: RTL and testbench
======================================

Name: audio_sample_feeder

Overview:
- Upstream stage of the ColorChord pipeline: accepts stereo codec samples, mixes them to mono signed 16-bit, and buffers them in a small FIFO.
- Presents the buffer head to the DFT on `inputSample`/`sampleReady`.
- Pops the head when the DFT pulses `doingRead`.
- Decouples the codec sample strobe from DFT scheduling. Counts dropped samples (overflow) and ignored reads (underflow) for debug.

Parameters:
- IN_WIDTH, 24, codec sample width per channel (signed).
- N, 16, output sample width (signed); matches the DFT data width.
- DEPTH, 16, FIFO depth in samples; power of two, at least 4.
- DC_IIR, 10, DC-blocker IIR shift constant (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- leftIn  input  IN_WIDTH  left codec sample, signed.
- rightIn  input  IN_WIDTH  right codec sample, signed.
- codecValid  input  1  one-cycle strobe; `leftIn`/`rightIn` are valid this cycle.
- doingRead  input  1  one-cycle pop request from the DFT.
- inputSample  output  N  FIFO head, signed.
- sampleReady  output  1  FIFO not empty.
- fillLevel  output  $clog2(DEPTH)+1  current occupancy.
- overflowCount  output  16  saturating count of dropped samples.
- underflowCount  output  16  saturating count of pops attempted while empty.

Behaviour:
- Reset (async, active-high): all outputs 0, read/write pointers 0, mix stage invalid, DC estimate 0.
  - Assertion mid-operation discards buffered and in-flight samples immediately.
  - FIFO memory contents are not reset.
- Stage 1, mix (registered at the edge where `codecValid`=1):
  - sum = sign-extended L + R (IN_WIDTH+1 bits).
  - mono = sum >>> 1 (arithmetic).
  - mixed = mono[IN_WIDTH-1 : IN_WIDTH-N], truncation, no rounding.
  - A valid flag is registered alongside.
- Stage 2, write: at the next edge, if the mix valid flag is set, the sample is written at the write pointer.
- Latency: `codecValid` at edge k produces `sampleReady`=1 in the cycle after edge k+1 (2 edges), given the FIFO was empty and not full.
- Back-to-back `codecValid` every cycle is supported at full throughput.
- Output timing:
  - `sampleReady` = (fillLevel != 0).
  - `inputSample` = memory[rdptr] when not empty, else 0 (forced).
  - Both are stable until a pop.
- Pop: `doingRead`=1 with `sampleReady`=1 advances rdptr at that edge; the next head is visible the following cycle.
- Underflow: `doingRead`=1 with `sampleReady`=0 changes no pointer and increments `underflowCount`.
- Overflow: a write with fillLevel==DEPTH and no simultaneous pop drops the incoming sample and increments `overflowCount`. The buffered contents are untouched.
- Simultaneous write and pop:
  - Both occur; fillLevel is unchanged.
  - When full, the write succeeds because the pop frees a slot the same edge; no overflow.
  - When empty, the write lands, the pop counts as underflow, and fillLevel goes 0→1.
- Pointers are $clog2(DEPTH)+1 bits; wrap is natural modulo 2·DEPTH. full = MSBs differ and LSBs equal.
- Counters saturate at 16'hFFFF; no wrap.

Optional Feature:
- Macro: `SAMPLE_DC_BLOCK_EN`.
- With the macro defined, Stage 1 adds a DC blocker on the mixed sample x:
  - est is a signed N+DC_IIR fixed-point register.
  - Each valid sample: est <= est + (((x <<< DC_IIR) - est) >>> DC_IIR).
  - Written value = sat_N(x - est[N+DC_IIR-1:DC_IIR]), saturating to [-32768, 32767].
  - Latency is unchanged; the subtraction uses est before the update.
- Without the macro: no est register; mixed is written directly.

Decomposition:
- CCHW package additions:
  - typedef `sample_t` (logic signed [15:0]).
  - localparam `SAMPLE_WIDTH`=16.
  - function `sat16` (signed saturation to 16 bits).
- Sub-module `sample_fifo`: parameterised DEPTH/N.
  - Contains pointers, memory, fillLevel, full/empty, and overflow/underflow detection.
- The top of this block holds the mix stage, the optional DC blocker and the counters.

Test Plan:
- Reset, then one `codecValid` with L=24'h010000, R=24'h030000 → `sampleReady` rises 2 edges later; `inputSample`=16'h0200; fillLevel=1.
- L=24'h800000, R=24'h800000 → `inputSample`=16'h8000.
  - Then a `doingRead` pulse → next cycle `sampleReady`=0 and `inputSample`=0.
- Write DEPTH+3 samples with no reads → fillLevel=DEPTH and overflowCount=3.
  - Draining DEPTH reads returns the first DEPTH samples in order.
- Full FIFO with `doingRead` and a mix-stage write on the same edge → fillLevel stays DEPTH, overflowCount unchanged, order preserved.
- Three `doingRead` pulses while empty → underflowCount=3, pointers unchanged. Async `rst` pulse mid-burst → all outputs 0 within the same cycle.
- With `SAMPLE_DC_BLOCK_EN`, constant L=R=24'h100000 for 20000 samples → `inputSample` converges to within ±2 of 0 with no saturation glitch.

Source files
------------

// File: rtl/audio_sample_feeder_pkg.sv
// Shared types and helpers for the audio sample feeder: the sample type and a 16-bit saturating clamp.
package audio_sample_feeder_pkg;

    localparam int SAMPLE_WIDTH = 16;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    function automatic sample_t sat16(input logic signed [31:0] v);
        sample_t r;
        if (v > 32'sd32767)
            r = 16'sh7FFF;
        else if (v < -32'sd32768)
            r = 16'sh8000;
        else
            r = v[15:0];
        return r;
    endfunction

endpackage

// File: rtl/audio_sample_feeder_if.sv
// Codec-side and DFT-side signals of the sample feeder; master drives the codec strobe and pops, slave is the feeder.
interface audio_sample_feeder_if #(
    parameter int IN_WIDTH = 24,
    parameter int N        = 16,
    parameter int DEPTH    = 16
);
    logic signed [IN_WIDTH-1:0] leftIn;
    logic signed [IN_WIDTH-1:0] rightIn;
    logic                       codecValid;
    logic                       doingRead;
    logic signed [N-1:0]        inputSample;
    logic                       sampleReady;
    logic [$clog2(DEPTH):0]     fillLevel;
    logic [15:0]                overflowCount;
    logic [15:0]                underflowCount;

    modport master (
        output leftIn, rightIn, codecValid, doingRead,
        input  inputSample, sampleReady, fillLevel, overflowCount, underflowCount
    );

    modport slave (
        input  leftIn, rightIn, codecValid, doingRead,
        output inputSample, sampleReady, fillLevel, overflowCount, underflowCount
    );
endinterface

// File: rtl/audio_sample_feeder_sample_fifo.sv
// Sample buffer between the mix stage and the DFT: pointer FIFO with forced-zero head when empty
// and one-cycle overflow/underflow event pulses.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int N     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [N-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [N-1:0]           rd_data,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         empty;
    logic         full;
    logic         do_pop;
    logic         do_write;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop on the same edge frees the slot a write to a full buffer needs.
    assign do_pop    = rd_en && !empty;
    assign do_write  = wr_en && (!full || do_pop);
    assign overflow  = wr_en && full && !do_pop;
    assign underflow = rd_en && empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_write) wptr <= wptr + 1'b1;
            if (do_pop)   rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wptr[AW-1:0]] <= wr_data;
    end

    assign fill_level = wptr - rptr;
    assign not_empty  = !empty;
    assign rd_data    = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/audio_sample_feeder.sv
// Stereo-to-mono mix stage, optional DC blocker (SAMPLE_DC_BLOCK_EN) and debug counters in front of
// the sample FIFO that feeds the DFT.
module audio_sample_feeder
    import audio_sample_feeder_pkg::*;
#(
    parameter int IN_WIDTH = 24,
    parameter int N        = 16,
    parameter int DEPTH    = 16,
    parameter int DC_IIR   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    audio_sample_feeder_if.slave bus
);
    logic signed [IN_WIDTH:0] mix_sum;
    logic signed [N-1:0]      mixed;
    logic signed [N-1:0]      stage_data;
    logic signed [N-1:0]      mix_data;
    logic                     mix_valid;
    logic                     ovf_evt;
    logic                     unf_evt;
    logic [15:0]              ovf_cnt;
    logic [15:0]              unf_cnt;

    assign mix_sum = {bus.leftIn[IN_WIDTH-1], bus.leftIn} + {bus.rightIn[IN_WIDTH-1], bus.rightIn};
    // Halving and dropping the low IN_WIDTH-N bits fold into one arithmetic shift of the sum.
    assign mixed   = N'(mix_sum >>> (IN_WIDTH - N + 1));

`ifdef SAMPLE_DC_BLOCK_EN
    localparam int EW = N + DC_IIR;

    logic signed [EW-1:0] est;
    logic signed [EW:0]   est_err;
    logic signed [EW:0]   est_step;
    logic signed [N:0]    blocked;

    assign est_err    = $signed({mixed[N-1], mixed, {DC_IIR{1'b0}}}) - $signed({est[EW-1], est});
    assign est_step   = est_err >>> DC_IIR;
    assign blocked    = $signed({mixed[N-1], mixed}) - $signed({est[EW-1], est[EW-1:DC_IIR]});
    assign stage_data = sat16(32'(blocked));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            est <= '0;
        else if (bus.codecValid)
            est <= est + est_step[EW-1:0];
    end
`else
    assign stage_data = mixed;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mix_valid <= 1'b0;
            mix_data  <= '0;
        end else begin
            mix_valid <= bus.codecValid;
            if (bus.codecValid) mix_data <= stage_data;
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .N     (N)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (mix_valid),
        .wr_data    (mix_data),
        .rd_en      (bus.doingRead),
        .rd_data    (bus.inputSample),
        .not_empty  (bus.sampleReady),
        .fill_level (bus.fillLevel),
        .overflow   (ovf_evt),
        .underflow  (unf_evt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else begin
            if (ovf_evt && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            if (unf_evt && unf_cnt != 16'hFFFF) unf_cnt <= unf_cnt + 16'd1;
        end
    end

    assign bus.overflowCount  = ovf_cnt;
    assign bus.underflowCount = unf_cnt;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed and randomized checks of audio_sample_feeder against a queue-based reference model.
module tb_audio_sample_feeder;
    localparam int IN_WIDTH = 24;
    localparam int N        = 16;
    localparam int DEPTH    = 16;
    localparam int DC_IIR   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    audio_sample_feeder_if #(.IN_WIDTH(IN_WIDTH), .N(N), .DEPTH(DEPTH)) bus ();

    audio_sample_feeder #(
        .IN_WIDTH (IN_WIDTH),
        .N        (N),
        .DEPTH    (DEPTH),
        .DC_IIR   (DC_IIR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] q[$];
    bit          pend_v;
    logic [15:0] pend_d;
    int          m_ovf;
    int          m_unf;
    longint      m_est;

    function automatic int mix(logic [23:0] l, logic [23:0] r);
        int s;
        s = int'($signed(l)) + int'($signed(r));
        return s >>> 9;
    endfunction

    function automatic logic [15:0] model_sample(logic [23:0] l, logic [23:0] r);
        int x;
        int y;
        x = mix(l, r);
`ifdef SAMPLE_DC_BLOCK_EN
        y = x - int'(m_est >>> DC_IIR);
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        m_est = m_est + (((longint'(x) <<< DC_IIR) - m_est) >>> DC_IIR);
`else
        y = x;
`endif
        return y[15:0];
    endfunction

    task automatic model_reset();
        q.delete();
        pend_v = 1'b0;
        pend_d = '0;
        m_ovf  = 0;
        m_unf  = 0;
        m_est  = 0;
    endtask

    task automatic model_edge(bit cv, logic [23:0] l, logic [23:0] r, bit rd);
        bit was_full;
        bit pop_ok;
        was_full = (q.size() == DEPTH);
        pop_ok   = rd && (q.size() > 0);
        if (rd && q.size() == 0 && m_unf < 65535) m_unf++;
        if (pop_ok) void'(q.pop_front());
        if (pend_v) begin
            if (was_full && !pop_ok) begin
                if (m_ovf < 65535) m_ovf++;
            end else begin
                q.push_back(pend_d);
            end
        end
        pend_v = cv;
        if (cv) pend_d = model_sample(l, r);
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".ready"}, 16'(bus.sampleReady), 16'(q.size() != 0));
        chk({tag, ".sample"}, bus.inputSample, (q.size() != 0) ? q[0] : 16'h0000);
        chk({tag, ".fill"}, 16'(bus.fillLevel), 16'(q.size()));
        chk({tag, ".ovf"}, bus.overflowCount, 16'(m_ovf));
        chk({tag, ".unf"}, bus.underflowCount, 16'(m_unf));
    endtask

    task automatic step(string tag, bit cv, logic [23:0] l, logic [23:0] r, bit rd);
        bus.codecValid = cv;
        bus.leftIn     = l;
        bus.rightIn    = r;
        bus.doingRead  = rd;
        @(posedge clk);
        model_edge(cv, l, r, rd);
        #1;
        check_all(tag);
    endtask

    task automatic idle(string tag);
        step(tag, 1'b0, 24'h0, 24'h0, 1'b0);
    endtask

    initial begin
        logic [23:0] l;
        logic [23:0] r;
        bus.codecValid = 1'b0;
        bus.doingRead  = 1'b0;
        bus.leftIn     = '0;
        bus.rightIn    = '0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // basic mix and latency
        step("t1_strobe", 1'b1, 24'h010000, 24'h030000, 1'b0);
        chk("t1_not_ready_yet", 16'(bus.sampleReady), 16'h0);
        idle("t1_write");
        chk("t1_ready", 16'(bus.sampleReady), 16'h1);
        chk("t1_value", bus.inputSample, 16'h0200);
        chk("t1_fill", 16'(bus.fillLevel), 16'h1);
        step("t1_pop", 1'b0, 24'h0, 24'h0, 1'b1);

        // most negative inputs, then pop to empty
        step("t2_strobe", 1'b1, 24'h800000, 24'h800000, 1'b0);
        idle("t2_write");
        chk("t2_value", bus.inputSample, 16'h8000);
        step("t2_pop", 1'b0, 24'h0, 24'h0, 1'b1);
        chk("t2_empty_ready", 16'(bus.sampleReady), 16'h0);
        chk("t2_empty_sample", bus.inputSample, 16'h0000);

        // overflow: DEPTH+3 writes, no reads
        for (int i = 0; i < DEPTH + 3; i++)
            step("t3_fill", 1'b1, 24'($urandom), 24'($urandom), 1'b0);
        idle("t3_last");
        chk("t3_fill_level", 16'(bus.fillLevel), 16'(DEPTH));
        chk("t3_ovf", bus.overflowCount, 16'd3);

        // full buffer: pop and write on the same edge
        step("t4_strobe", 1'b1, 24'($urandom), 24'($urandom), 1'b0);
        step("t4_popwr", 1'b0, 24'h0, 24'h0, 1'b1);
        chk("t4_fill_level", 16'(bus.fillLevel), 16'(DEPTH));
        chk("t4_ovf", bus.overflowCount, 16'd3);
        for (int i = 0; i < DEPTH; i++)
            step("t4_drain", 1'b0, 24'h0, 24'h0, 1'b1);

        // underflow while empty
        for (int i = 0; i < 3; i++)
            step("t5_under", 1'b0, 24'h0, 24'h0, 1'b1);
        chk("t5_unf", bus.underflowCount, 16'd3);
        chk("t5_fill", 16'(bus.fillLevel), 16'h0);

        // empty buffer: write and pop on the same edge
        step("t6_strobe", 1'b1, 24'($urandom), 24'($urandom), 1'b0);
        step("t6_popwr", 1'b0, 24'h0, 24'h0, 1'b1);
        chk("t6_fill", 16'(bus.fillLevel), 16'h1);
        chk("t6_unf", bus.underflowCount, 16'd4);

        // randomized traffic with varying producer/consumer rates
        for (int i = 0; i < 400; i++) begin
            int wr_pct;
            int rd_pct;
            wr_pct = (i < 200) ? 70 : 35;
            rd_pct = (i < 200) ? 35 : 70;
            l = 24'($urandom);
            r = 24'($urandom);
            if (($urandom % 8) == 0) begin
                l = 24'h7FFFFF;
                r = 24'h7FFFFF;
            end
            step("rand", ($urandom_range(99) < wr_pct), l, r, ($urandom_range(99) < rd_pct));
        end

        // async reset mid-burst
        for (int i = 0; i < 6; i++)
            step("t7_burst", 1'b1, 24'($urandom), 24'($urandom), 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t7_rst_ready", 16'(bus.sampleReady), 16'h0);
        chk("t7_rst_sample", bus.inputSample, 16'h0000);
        chk("t7_rst_fill", 16'(bus.fillLevel), 16'h0);
        chk("t7_rst_ovf", bus.overflowCount, 16'h0);
        chk("t7_rst_unf", bus.underflowCount, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle("t7_after");
        step("t7_strobe", 1'b1, 24'h020000, 24'h020000, 1'b0);
        idle("t7_write");
        step("t7_pop", 1'b0, 24'h0, 24'h0, 1'b1);

`ifdef SAMPLE_DC_BLOCK_EN
        for (int i = 0; i < 20000; i++)
            step("dc", 1'b1, 24'h100000, 24'h100000, 1'b1);
        idle("dc_tail");
        begin
            int v;
            v = int'(bus.inputSample);
            chk("dc_converged", 16'(v >= -2 && v <= 2), 16'h1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
